// File: rtl/serial_rx_controller.sv
// serial_rx_controller: control FSM for the serial port-routing datapath
// Hunts for a start bit on SerIn, sequences shifting of a 2-bit port and a
// 4-bit length, loads the payload down-counter and holds routing open for N bits.
// Ports:
//   clk, rst (async, active-low)         clock and reset
//   Clk_EN, SerIn                        bit strobe and serial data
//   co1, co2, co_D                       datapath carry-outs
//   sh_en, cnt_1, sh_en_D, cnt_2,        datapath enables
//   ldcntD, cnt_D
//   tx_active, busy, done                status
module serial_rx_controller #(
    parameter logic START_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic Clk_EN,
    input  logic SerIn,
    input  logic co1,
    input  logic co2,
    input  logic co_D,
    output logic sh_en,
    output logic cnt_1,
    output logic sh_en_D,
    output logic cnt_2,
    output logic ldcntD,
    output logic cnt_D,
    output logic tx_active,
    output logic busy,
    output logic done
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PORT = 3'd1,
        LEN  = 3'd2,
        LOAD = 3'd3,
        XFER = 3'd4
    } state_t;

    state_t state, nxt;

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = (Clk_EN && SerIn == START_BIT) ? PORT : IDLE;
            PORT:    nxt = (Clk_EN && co1) ? LEN : PORT;
            LEN:     nxt = (Clk_EN && co2) ? LOAD : LEN;
            LOAD:    nxt = Clk_EN ? XFER : LOAD;
            XFER:    nxt = co_D ? IDLE : XFER;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they equal a decode of
    // the current state without any combinational path to the pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sh_en     <= 1'b0;
            cnt_1     <= 1'b0;
            sh_en_D   <= 1'b0;
            cnt_2     <= 1'b0;
            ldcntD    <= 1'b0;
            cnt_D     <= 1'b0;
            tx_active <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt;
            sh_en     <= nxt == PORT;
            cnt_1     <= nxt == PORT;
            sh_en_D   <= nxt == LEN;
            cnt_2     <= nxt == LEN;
            ldcntD    <= nxt == LOAD;
            cnt_D     <= nxt == XFER;
            tx_active <= nxt == XFER;
            busy      <= nxt != IDLE;
            done      <= state == XFER && co_D;
        end
    end
endmodule

// File: tb/tb_serial_rx_controller.sv
// tb_serial_rx_controller: directed self-checking bench with a behavioural datapath
module tb_serial_rx_controller;
    logic clk = 1'b0, rst = 1'b0, Clk_EN = 1'b0, SerIn = 1'b0;
    logic [2:0] tg = 3'b000;
    logic co1, co2, co_D;
    logic sh_en, cnt_1, sh_en_D, cnt_2, ldcntD, cnt_D, tx_active, busy, done;
    logic [1:0] p_reg, c2;
    logic [3:0] l_reg, cd;
    logic c1;
    logic [8:0] outs;
    int compared = 0, mismatched = 0;
    int n_sh, n_shd, n_ld, n_cd, n_tx, n_done, n_bad;

    serial_rx_controller dut (
        .clk(clk), .rst(rst), .Clk_EN(Clk_EN), .SerIn(SerIn),
        .co1(co1), .co2(co2), .co_D(co_D),
        .sh_en(sh_en), .cnt_1(cnt_1), .sh_en_D(sh_en_D), .cnt_2(cnt_2),
        .ldcntD(ldcntD), .cnt_D(cnt_D), .tx_active(tx_active),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign outs = {sh_en, cnt_1, sh_en_D, cnt_2, ldcntD, cnt_D, tx_active, busy, done};
    assign co1  = (c1 == 1'b1) ^ tg[0];
    assign co2  = (c2 == 2'd3) ^ tg[1];
    assign co_D = (cd == 4'd0) ^ tg[2];

    // behavioural datapath: registers and counters driven by the FSM enables
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_reg <= '0; l_reg <= '0; c1 <= '0; c2 <= '0; cd <= '0;
        end else if (Clk_EN) begin
            if (sh_en) p_reg <= {p_reg[0], SerIn};
            if (cnt_1) c1 <= c1 + 1'b1;
            if (sh_en_D) l_reg <= {l_reg[2:0], SerIn};
            if (cnt_2) c2 <= c2 + 2'd1;
            if (ldcntD) cd <= l_reg;
            else if (cnt_D && cd != 4'd0) cd <= cd - 4'd1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (Clk_EN && sh_en) n_sh++;
            if (Clk_EN && sh_en_D) n_shd++;
            if (Clk_EN && ldcntD) n_ld++;
            if (Clk_EN && cnt_D) n_cd++;
            if (tx_active) n_tx++;
            if (done) n_done++;
            if (done && busy) n_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_sh = 0; n_shd = 0; n_ld = 0; n_cd = 0; n_tx = 0; n_done = 0; n_bad = 0;
    endtask

    task automatic strobe(input logic b);
        @(posedge clk); #1;
        SerIn = b; Clk_EN = 1'b1;
        @(posedge clk); #1;
        Clk_EN = 1'b0;
        @(posedge clk);
    endtask

    task automatic hdr(input logic [1:0] p, input logic [3:0] n);
        strobe(1'b0);
        strobe(p[1]); strobe(p[0]);
        for (int i = 3; i >= 0; i--) strobe(n[i]);
        strobe(1'($urandom_range(1)));
    endtask

    task automatic frame(input logic [1:0] p, input logic [3:0] n);
        hdr(p, n);
        for (int i = 0; i < int'(n); i++) strobe(1'($urandom_range(1)));
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic stable;
        clr();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            SerIn = ~SerIn; Clk_EN = ~Clk_EN; tg = 3'($urandom);
            @(negedge clk);
            chk("rst_outs", outs, 0);
        end
        tg = 3'b000; Clk_EN = 1'b0;
        @(negedge clk) rst = 1'b1;
        strobe(1'b1);
        @(negedge clk);
        chk("idle_on_one", outs, 0);

        clr();
        frame(2'b10, 4'd3);
        settle();
        chk("nom_sh", n_sh, 2);
        chk("nom_shd", n_shd, 4);
        chk("nom_ld", n_ld, 1);
        chk("nom_cd", n_cd, 3);
        chk("nom_tx", n_tx, 10);
        chk("nom_done", n_done, 1);
        chk("nom_done_busy", n_bad, 0);
        chk("nom_port", p_reg, 2'b10);
        chk("nom_idle", outs, 0);

        clr();
        frame(2'b11, 4'd0);
        settle();
        chk("zero_tx", n_tx, 1);
        chk("zero_cd", n_cd, 0);
        chk("zero_done", n_done, 1);
        chk("zero_done_busy", n_bad, 0);
        chk("zero_port", p_reg, 2'b11);

        clr();
        frame(2'b10, 4'd2);
        frame(2'b01, 4'd1);
        settle();
        chk("b2b_done", n_done, 2);
        chk("b2b_sh", n_sh, 4);
        chk("b2b_cd", n_cd, 3);
        chk("b2b_tx", n_tx, 11);
        chk("b2b_port", p_reg, 2'b01);

        strobe(1'b0); strobe(1'b1); strobe(1'b0); strobe(1'b1);
        @(negedge clk);
        chk("in_len", outs, 9'b001100010);
        #1 rst = 1'b0;
        #1 chk("rst_len_async", outs, 0);
        @(negedge clk) rst = 1'b1;

        hdr(2'b00, 4'd15);
        repeat (5) strobe(1'b1);
        @(negedge clk);
        chk("in_xfer", outs, 9'b000001110);
        #1 rst = 1'b0;
        #1 chk("rst_xfer_async", outs, 0);
        @(negedge clk) rst = 1'b1;

        clr();
        frame(2'b01, 4'd2);
        settle();
        chk("clean_done", n_done, 1);
        chk("clean_port", p_reg, 2'b01);
        chk("clean_cd", n_cd, 2);

        clr();
        strobe(1'b0); strobe(1'b1);
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (outs !== 9'b110000010) stable = 1'b0;
        end
        chk("starve_port", stable, 1'b1);
        strobe(1'b1);
        strobe(1'b0); strobe(1'b0);
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (outs !== 9'b001100010) stable = 1'b0;
        end
        chk("starve_len", stable, 1'b1);
        strobe(1'b1); strobe(1'b0);
        strobe(1'b0);
        strobe(1'b1); strobe(1'b0);
        settle();
        chk("starve_port_val", p_reg, 2'b11);
        chk("starve_sh", n_sh, 2);
        chk("starve_shd", n_shd, 4);
        chk("starve_cd", n_cd, 2);
        chk("starve_done", n_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/serial_rx_controller.md
# serial_rx_controller

Control FSM for the serial port-routing datapath: hunts for a start bit on `SerIn`, then sequences the datapath to shift in a 2-bit port number and a 4-bit payload length. It loads the payload down-counter and holds the demux routing open for exactly that many payload bits before returning to idle. It sits beside the datapath, consumes its `Clk_EN` pulse and carry-outs, and drives every enable the datapath exposes.

## Interface
- `START_BIT`, default 1'b0, `SerIn` level recognised as a start bit in IDLE.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset; forces IDLE.
- `Clk_EN`  in  1  one-`clk`-wide bit-strobe from the datapath one-pulser; one serial bit per pulse.
- `SerIn`  in  1  serial data, sampled only when `Clk_EN`=1.
- `co1`  in  1  port-bit counter (1-bit, up) at terminal count 1.
- `co2`  in  1  length-bit counter (2-bit, up) at terminal count 3.
- `co_D`  in  1  payload down-counter equals 0.
- `sh_en`  out  1  shift enable, port-number register.
- `cnt_1`  out  1  count enable, port-bit counter.
- `sh_en_D`  out  1  shift enable, length register.
- `cnt_2`  out  1  count enable, length-bit counter.
- `ldcntD`  out  1  load payload down-counter from length register.
- `cnt_D`  out  1  payload down-counter decrement enable.
- `tx_active`  out  1  demux routing valid; `SerIn` is being forwarded to the selected port.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-`clk` pulse on frame completion.

## Operation
- Frame on `SerIn`, one bit per `Clk_EN`:
  - start bit;
  - 2 port bits, MSB first;
  - 4 length bits N, MSB first;
  - 1 gap bit, ignored;
  - N payload bits.
- Moore FSM. All outputs decode from state only, except `done`, which is registered.
- States and transitions:
  - IDLE: all enables 0. On `Clk_EN`=1 with `SerIn`=`START_BIT`, go to PORT. Any other bit stays in IDLE.
  - PORT: `sh_en`=`cnt_1`=1. On `Clk_EN`=1 with `co1`=1, go to LEN (second port bit shifted on that same strobe).
  - LEN: `sh_en_D`=`cnt_2`=1. On `Clk_EN`=1 with `co2`=1, go to LOAD (fourth length bit shifted).
  - LOAD: `ldcntD`=1. On `Clk_EN`=1, go to XFER; the counter loads N on that strobe, consuming the gap bit.
  - XFER: `cnt_D`=`tx_active`=1. On any `clk` edge where `co_D`=1, go to IDLE and pulse `done`. Otherwise stay.
- Counter housekeeping is not done by this block. The bit counters wrap to 0 on the strobe that raises their carry, so they are clear for the next frame.
- N=0: XFER is entered with `co_D`=1 and exits on the next `clk` with no payload strobe. `tx_active` is high for exactly 1 `clk` and no bit is counted.
- N=15: XFER consumes 15 strobes.
- Unused state encodings recover to IDLE on the next `clk`.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state = IDLE;
  - all outputs 0, including `done`, `busy` and `tx_active`.
- Release is synchronous to the first `clk` rising edge with `rst`=1.
- Reset mid-frame aborts immediately. Datapath registers are reset by the same `rst`, so no partial frame survives.
- Without `Clk_EN` the FSM holds any state indefinitely, except XFER exit, which is `co_D`-driven.
- Enables change one `clk` after the qualifying strobe. They are therefore stable across the whole inter-strobe gap, which is at least 2 `clk`.
- `done` rises on the `clk` edge that leaves XFER, lasts 1 `clk`, and coincides with the first IDLE cycle.
- Back-to-back frames:
  - a start bit on the first strobe after returning to IDLE is accepted;
  - no dead bit is required beyond the gap bit.
- Frame latency in strobes: 1 + 2 + 4 + 1 + N.

## Test plan
- Reset: hold `rst`=0 for 3 `clk`, with `SerIn`, `Clk_EN` and the carries toggling.
  - Required: all outputs 0, `busy`=0.
  - Required: the first strobe after release with `SerIn`=1 leaves the FSM in IDLE.
- Nominal frame: start 0, port 10, length 0011, gap, 3 payload bits.
  - Required: `sh_en` high for 2 strobes, `sh_en_D` for 4 strobes, `ldcntD` for 1 strobe.
  - Required: `cnt_D` and `tx_active` high until `co_D`, then a single-`clk` `done`, with `busy` falling in the same cycle.
- Zero length: length 0000.
  - Required: `tx_active` high for exactly 1 `clk`, then `done`.
  - Required: no `cnt_D` strobe overlaps a `Clk_EN`.
- Back-to-back: second start bit on the first strobe after `done`.
  - Required: PORT entered immediately and the second frame's port latched correctly.
- Mid-frame reset: pulse `rst` low asynchronously during LEN and again during XFER with N=15.
  - Required: outputs drop to 0 without waiting for `clk`.
  - Required: a subsequent clean frame completes normally.
- Strobe starvation: stop `Clk_EN` for 50 `clk` inside PORT and inside LEN.
  - Required: state and enables are unchanged throughout, and the frame resumes correctly.
